// File: rtl/counter_two_digit_pkg.sv
// Shared types and limits for the two-digit BCD counter.
package counter_two_digit_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

endpackage

// File: rtl/counter_two_digit_if.sv
// Display-side bundle of the counter outputs (digits plus optional cascade carry).
interface counter_two_digit_if;
  import counter_two_digit_pkg::*;

  bcd_digit_t dig1;
  bcd_digit_t dig0;
  logic       carry;

  modport master (output dig1, output dig0, output carry);
  modport slave  (input  dig1, input  dig0, input  carry);

endinterface

// File: rtl/counter_two_digit_bcd_digit.sv
// One BCD digit: mod-(max+1) counter with enable and terminal-count flag.
module bcd_digit
  import counter_two_digit_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  bcd_digit_t max,
  output bcd_digit_t q,
  output logic       tc
);

  // An out-of-range value is cleared on the next edge even when not enabled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (q > max) begin
      q <= '0;
    end else if (en) begin
      q <= (q == max) ? 4'd0 : q + 4'd1;
    end
  end

  assign tc = en && (q == max);

endmodule

// File: rtl/counter_two_digit.sv
// Free-running two-digit BCD counter, wraps at {DIG1_MAX,DIG0_MAX}.
// Optional cascade output `carry` enabled by COUNTER_TWO_DIGIT_CARRY_EN.
module counter_two_digit
  import counter_two_digit_pkg::*;
#(
  parameter int DIG0_MAX = 9,
  parameter int DIG1_MAX = 9
) (
  input  logic       clock,
  input  logic       reset,
  output bcd_digit_t dig1,
  output bcd_digit_t dig0
`ifdef COUNTER_TWO_DIGIT_CARRY_EN
  ,
  output logic       carry
`endif
);

  // Out-of-range parameters are clamped so the digits stay valid BCD.
  localparam bcd_digit_t D0_MAX = (DIG0_MAX > 9) ? BCD_MAX : bcd_digit_t'(DIG0_MAX);
  localparam bcd_digit_t D1_MAX = (DIG1_MAX > 9) ? BCD_MAX : bcd_digit_t'(DIG1_MAX);

  logic ones_tc;
  logic tens_tc;

  bcd_digit u_ones (
    .clock (clock),
    .reset (reset),
    .en    (1'b1),
    .max   (D0_MAX),
    .q     (dig0),
    .tc    (ones_tc)
  );

  bcd_digit u_tens (
    .clock (clock),
    .reset (reset),
    .en    (ones_tc),
    .max   (D1_MAX),
    .q     (dig1),
    .tc    (tens_tc)
  );

`ifdef COUNTER_TWO_DIGIT_CARRY_EN
  assign carry = tens_tc && reset;
`else
  logic unused_tc;
  assign unused_tc = tens_tc;
`endif

endmodule

// File: tb/tb_counter_two_digit.sv
// Directed bench for counter_two_digit: mod-100 and mod-60 instances share clock/reset.
`timescale 1ns/1ps
module tb_counter_two_digit;
  import counter_two_digit_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   ec    = 0;
  int   pulses;

  counter_two_digit_if u_if ();
  bcd_digit_t dig1_60, dig0_60;
  logic       carry60;

  always #5 clock = ~clock;

  counter_two_digit #(.DIG0_MAX(9), .DIG1_MAX(9)) u_dut (
    .clock (clock),
    .reset (reset),
    .dig1  (u_if.dig1),
    .dig0  (u_if.dig0)
`ifdef COUNTER_TWO_DIGIT_CARRY_EN
    ,
    .carry (u_if.carry)
`endif
  );

  counter_two_digit #(.DIG0_MAX(9), .DIG1_MAX(5)) u_dut60 (
    .clock (clock),
    .reset (reset),
    .dig1  (dig1_60),
    .dig0  (dig0_60)
`ifdef COUNTER_TWO_DIGIT_CARRY_EN
    ,
    .carry (carry60)
`endif
  );

`ifndef COUNTER_TWO_DIGIT_CARRY_EN
  assign u_if.carry = 1'b0;
  assign carry60    = 1'b0;
`endif

  function automatic logic [7:0] bcd(input int n);
    logic [3:0] t, o;
    t = 4'((n / 10) % 10);
    o = 4'(n % 10);
    return {t, o};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_both(input string tag);
    chk({tag, "_m100"}, {u_if.dig1, u_if.dig0}, bcd(ec % 100));
    chk({tag, "_m60"},  {dig1_60, dig0_60},     bcd(ec % 60));
    chk({tag, "_m60_tens_le5"}, {7'd0, (dig1_60 <= 4'd5)}, 8'd1);
`ifdef COUNTER_TWO_DIGIT_CARRY_EN
    chk({tag, "_carry"}, {7'd0, u_if.carry}, {7'd0, ((ec % 100) == 99)});
    chk({tag, "_carry60"}, {7'd0, carry60}, {7'd0, ((ec % 60) == 59)});
`endif
  endtask

  task automatic step(input string tag);
    @(posedge clock);
    ec++;
    @(negedge clock);
    chk_both(tag);
  endtask

  initial begin
    // reset held with clock running
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("in_reset", {u_if.dig1, u_if.dig0}, 8'h00);
      chk("in_reset_m60", {dig1_60, dig0_60}, 8'h00);
`ifdef COUNTER_TWO_DIGIT_CARRY_EN
      chk("in_reset_carry", {7'd0, u_if.carry}, 8'd0);
`endif
    end

    reset = 1'b1;
    ec = 0;
    step("first_edge");
    chk("first_edge_01", {u_if.dig1, u_if.dig0}, 8'h01);
    pulses = 0;
    for (int i = 2; i <= 100; i++) begin
      step("run");
      if (u_if.carry) pulses++;
      if (i == 10) chk("ten_edges", {u_if.dig1, u_if.dig0}, 8'h10);
      if (i == 60) chk("m60_wrap", {dig1_60, dig0_60}, 8'h00);
      if (i == 99) chk("at_99", {u_if.dig1, u_if.dig0}, 8'h99);
    end
    chk("wrap_00", {u_if.dig1, u_if.dig0}, 8'h00);
`ifdef COUNTER_TWO_DIGIT_CARRY_EN
    chk("carry_pulses", 8'(pulses), 8'd1);
`endif

    for (int i = 0; i < 47; i++) step("to_47");
    chk("at_47", {u_if.dig1, u_if.dig0}, 8'h47);

    // async reset between edges
    #2 reset = 1'b0;
    #1 chk("async_clr", {u_if.dig1, u_if.dig0}, 8'h00);
    chk("async_clr_m60", {dig1_60, dig0_60}, 8'h00);
    @(posedge clock);
    @(negedge clock);
    chk("held_clr", {u_if.dig1, u_if.dig0}, 8'h00);
    reset = 1'b1;
    ec = 0;
    step("restart");
    chk("restart_01", {u_if.dig1, u_if.dig0}, 8'h01);

    for (int i = 0; i < 98; i++) step("to_99");
    chk("again_99", {u_if.dig1, u_if.dig0}, 8'h99);
    #2 reset = 1'b0;
    #1 chk("clr_from_99", {u_if.dig1, u_if.dig0}, 8'h00);
`ifdef COUNTER_TWO_DIGIT_CARRY_EN
    chk("carry_in_reset", {7'd0, u_if.carry}, 8'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
